// File: rtl/ha_checker.sv
`default_nettype none
// ============================================================================
//  Module   : ha_checker
//  Purpose  : Exhaustive stimulus generator and response checker for a
//             WIDTH-bit adder DUT ({carry,sum} = a + b) with LAT-cycle latency.
//             Optional macro HA_CHECKER_STOP_ON_FAIL_EN ends a run at the
//             first mismatch.
//  Revision : 1.0 - initial release
// ============================================================================
module ha_checker #(
    parameter int WIDTH = 1,
    parameter int LAT   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [WIDTH-1:0]     test_a,
    output logic [WIDTH-1:0]     test_b,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_carry,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_cnt,
    output logic                 fail_valid,
    output logic [2*WIDTH-1:0]   fail_vec
);

    localparam int c_vec_w = 2 * WIDTH;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_drive = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_check = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    // WAIT lasts LAT cycles: load LAT-1 and leave when the counter reads zero
    localparam logic [3:0]         c_wait_load = 4'(LAT > 0 ? LAT - 1 : 0);
    localparam logic [c_vec_w-1:0] c_vec_one   = c_vec_w'(1);
    localparam logic [c_vec_w:0]   c_err_one   = (c_vec_w + 1)'(1);

`ifdef HA_CHECKER_STOP_ON_FAIL_EN
    localparam logic c_stop_on_fail = 1'b1;
`else
    localparam logic c_stop_on_fail = 1'b0;
`endif

    logic [2:0]         r_state;
    logic [c_vec_w-1:0] r_vec;
    logic [3:0]         r_wait;
    logic [WIDTH-1:0]   r_test_a;
    logic [WIDTH-1:0]   r_test_b;
    logic [c_vec_w:0]   r_err_cnt;
    logic               r_fail_valid;
    logic [c_vec_w-1:0] r_fail_vec;

    logic [WIDTH:0]     w_expected;
    logic [WIDTH:0]     w_got;
    logic               w_mismatch;
    logic               w_finish;

    assign w_expected = {1'b0, r_test_a} + {1'b0, r_test_b};
    assign w_got      = {dut_carry, dut_sum};
    // Case inequality so X/Z from the DUT scores as a failure in simulation;
    // it reduces to an ordinary != in hardware.
    assign w_mismatch = (w_got !== w_expected);
    assign w_finish   = (&r_vec) | (c_stop_on_fail & w_mismatch);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_vec        <= '0;
            r_wait       <= '0;
            r_test_a     <= '0;
            r_test_b     <= '0;
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_vec        <= '0;
                        r_err_cnt    <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= '0;
                        r_state      <= c_st_drive;
                    end
                end
                c_st_drive: begin
                    r_test_a <= r_vec[c_vec_w-1:WIDTH];
                    r_test_b <= r_vec[WIDTH-1:0];
                    r_wait   <= c_wait_load;
                    r_state  <= (LAT == 0) ? c_st_check : c_st_wait;
                end
                c_st_wait: begin
                    if (r_wait == 4'd0) begin
                        r_state <= c_st_check;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                c_st_check: begin
                    if (w_mismatch) begin
                        r_err_cnt <= r_err_cnt + c_err_one;
                        if (!r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_fail_vec   <= {r_test_a, r_test_b};
                        end
                    end
                    if (w_finish) begin
                        r_state <= c_st_done;
                    end else begin
                        r_vec   <= r_vec + c_vec_one;
                        r_state <= c_st_drive;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign test_a     = r_test_a;
    assign test_b     = r_test_b;
    assign busy       = (r_state == c_st_drive) || (r_state == c_st_wait) ||
                        (r_state == c_st_check);
    assign done       = (r_state == c_st_done);
    assign pass       = done && (r_err_cnt == '0);
    assign err_cnt    = r_err_cnt;
    assign fail_valid = r_fail_valid;
    assign fail_vec   = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_ha_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ha_checker
//  Purpose  : Self-checking bench; two checker instances (W=1/LAT=0 and
//             W=2/LAT=2) each drive a configurable faulty adder model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ha_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [0:0] ta1, tb1, s1;
    logic       c1, busy1, done1, pass1, fv1;
    logic [2:0] err1;
    logic [1:0] fvec1;
    logic [1:0] ta2, tb2, s2;
    logic       c2, busy2, done2, pass2, fv2;
    logic [4:0] err2;
    logic [3:0] fvec2;

    ha_checker #(.WIDTH(1), .LAT(0)) u_chk1 (
        .clk(clk), .reset(reset), .start(start), .test_a(ta1), .test_b(tb1),
        .dut_sum(s1), .dut_carry(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_valid(fv1), .fail_vec(fvec1));

    ha_checker #(.WIDTH(2), .LAT(2)) u_chk2 (
        .clk(clk), .reset(reset), .start(start), .test_a(ta2), .test_b(tb2),
        .dut_sum(s2), .dut_carry(c2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_valid(fv2), .fail_vec(fvec2));

    int total = 0;
    int bad   = 0;

    int fault   [2];
    int dut_lat [2];
    bit badmask [2][16];
    int pipe    [2][16];

    function automatic int wid(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    // Adder under test: returns {carry,sum} for packed vector v = {a,b}
    function automatic int bench_dut(input int i, input int v);
        int w, a, b, r;
        w = wid(i);
        a = v >> w;
        b = v & ((1 << w) - 1);
        r = a + b;
        case (fault[i])
            1: r = r & (1 << w);
            2: r = r & ((1 << w) - 1);
            3: if (badmask[i][v]) r = r ^ 1;
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 15; k > 0; k--) begin
            pipe[0][k] <= pipe[0][k-1];
            pipe[1][k] <= pipe[1][k-1];
        end
        pipe[0][0] <= bench_dut(0, int'({ta1, tb1}));
        pipe[1][0] <= bench_dut(1, int'({ta2, tb2}));
    end

    int o1, o2;
    always_comb begin
        o1 = (dut_lat[0] == 0) ? bench_dut(0, int'({ta1, tb1})) : pipe[0][dut_lat[0]-1];
        o2 = (dut_lat[1] == 0) ? bench_dut(1, int'({ta2, tb2})) : pipe[1][dut_lat[1]-1];
        s1 = o1[0:0];
        c1 = o1[1];
        s2 = o2[1:0];
        c2 = o2[2];
    end

    // ---------------- reference model ----------------
    int n [2];
    bit running [2];
    int prev [2];
    int stop_k [2];
    bit fk [2][16];

    // Vector index presented on test_a/test_b in run cycle c
    function automatic int tv(input int i, input int c);
        if (c < 2) return prev[i];
        return (c - 2) / (2 + lat(i));
    endfunction

    function automatic int done_cycle(input int i);
        return (stop_k[i] + 1) * (2 + lat(i)) + 1;
    endfunction

    task automatic setup(input int i);
        int nv, p, w, a, b;
        bit found;
        w  = wid(i);
        nv = 1 << (2 * w);
        p  = 2 + lat(i);
        stop_k[i] = nv - 1;
        found = 0;
        for (int k = 0; k < nv; k++) begin
            a = k >> w;
            b = k & ((1 << w) - 1);
            fk[i][k] = (bench_dut(i, tv(i, (k + 1) * p - dut_lat[i])) != a + b);
`ifdef HA_CHECKER_STOP_ON_FAIL_EN
            if (fk[i][k] && !found) begin
                found = 1;
                stop_k[i] = k;
            end
`endif
        end
    endtask

    task automatic cmp(input string nm, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int i);
        int p, w, ev, e_err, e_fvec, dc;
        bit e_fv, e_done;
        int a_ta, a_tb, a_busy, a_done, a_pass, a_err, a_fv, a_fvec;
        if (i == 0) begin
            a_ta = ta1; a_tb = tb1; a_busy = busy1; a_done = done1; a_pass = pass1;
            a_err = err1; a_fv = fv1; a_fvec = fvec1;
        end else begin
            a_ta = ta2; a_tb = tb2; a_busy = busy2; a_done = done2; a_pass = pass2;
            a_err = err2; a_fv = fv2; a_fvec = fvec2;
        end
        w  = wid(i);
        p  = 2 + lat(i);
        dc = done_cycle(i);
        e_done = (n[i] >= dc);
        ev = (n[i] < 2) ? prev[i] : (((n[i] - 2) / p > stop_k[i]) ? stop_k[i] : (n[i] - 2) / p);
        e_err = 0; e_fv = 0; e_fvec = 0;
        for (int k = 0; k <= stop_k[i]; k++) begin
            if (fk[i][k] && ((k + 1) * p + 1 <= n[i])) begin
                e_err++;
                if (!e_fv) begin
                    e_fv = 1;
                    e_fvec = k;
                end
            end
        end
        cmp("test_a", i, a_ta, ev >> w);
        cmp("test_b", i, a_tb, ev & ((1 << w) - 1));
        cmp("busy", i, a_busy, int'(!e_done));
        cmp("done", i, a_done, int'(e_done));
        cmp("pass", i, a_pass, int'(e_done && e_err == 0));
        cmp("err_cnt", i, a_err, e_err);
        cmp("fail_valid", i, a_fv, int'(e_fv));
        cmp("fail_vec", i, a_fvec, e_fvec);
    endtask

    // Single compare process: tracks each instance's run cycle and checks every cycle
    always @(negedge clk) begin
        if (reset) begin
            running = '{0, 0};
            prev    = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start && (!running[i] || n[i] >= done_cycle(i))) begin
                    if (running[i]) prev[i] = stop_k[i];
                    running[i] = 1;
                    n[i] = 0;
                    setup(i);
                end else if (running[i]) begin
                    n[i]++;
                    check_inst(i);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset();
        cmp("rst_ta1", 0, int'(ta1), 0);     cmp("rst_tb1", 0, int'(tb1), 0);
        cmp("rst_busy1", 0, int'(busy1), 0); cmp("rst_done1", 0, int'(done1), 0);
        cmp("rst_pass1", 0, int'(pass1), 0); cmp("rst_err1", 0, int'(err1), 0);
        cmp("rst_fv1", 0, int'(fv1), 0);     cmp("rst_fvec1", 0, int'(fvec1), 0);
        cmp("rst_ta2", 1, int'(ta2), 0);     cmp("rst_tb2", 1, int'(tb2), 0);
        cmp("rst_busy2", 1, int'(busy2), 0); cmp("rst_done2", 1, int'(done2), 0);
        cmp("rst_pass2", 1, int'(pass2), 0); cmp("rst_err2", 1, int'(err2), 0);
        cmp("rst_fv2", 1, int'(fv2), 0);     cmp("rst_fvec2", 1, int'(fvec2), 0);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Start a run at cycle 0; optional extra start pulse and reset abort
    task automatic run(input int extra_start, input int abort_at, output int first1, output int first2);
        int t;
        first1 = -1;
        first2 = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t = 1;
        forever begin
            if (done1 && first1 < 0) first1 = t;
            if (done2 && first2 < 0) first2 = t;
            if (t == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
                break;
            end
            if (done1 && done2 && t > extra_start + 1) break;
            if (t > 300) begin
                total++;
                bad++;
                $display("FAIL run_timeout t=%0t: got busy1=%0d busy2=%0d expected done", $time, busy1, busy2);
                break;
            end
            start = (t == extra_start);
            @(posedge clk); #1 t++;
        end
        start = 1'b0;
    endtask

    initial begin
        int d1, d2;
        fault   = '{0, 0};
        dut_lat = '{0, 2};
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++) badmask[i][k] = 1'($urandom_range(0, 1));

        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check_reset();
        idle(4);

        // correct adders; start at cycle 3 ignored, at cycle 20 restarts inst1 only
        run(20, -1, d1, d2);
        cmp("lit_done_cyc1", 0, d1, 9);
        cmp("lit_done_cyc2", 1, d2, 65);
        cmp("lit_pass1", 0, int'(pass1), 1);
        cmp("lit_pass2", 1, int'(pass2), 1);
        run(3, -1, d1, d2);
        cmp("lit_rerun_err2", 1, int'(err2), 0);

        // sum stuck at 0 on inst1, carry stuck at 0 on inst2
        fault = '{1, 2};
        idle(4);
        run(-1, -1, d1, d2);
`ifdef HA_CHECKER_STOP_ON_FAIL_EN
        cmp("lit_stop_cyc1", 0, d1, 5);
        cmp("lit_stop_err1", 0, int'(err1), 1);
        cmp("lit_stop_ta1", 0, int'(ta1), 0);
        cmp("lit_stop_tb1", 0, int'(tb1), 1);
        cmp("lit_stop_err2", 1, int'(err2), 1);
        cmp("lit_stop_fvec2", 1, int'(fvec2), 7);
`else
        cmp("lit_sa0_cyc1", 0, d1, 9);
        cmp("lit_sa0_err1", 0, int'(err1), 2);
        cmp("lit_sa0_fvec1", 0, int'(fvec1), 1);
        cmp("lit_sa0_pass1", 0, int'(pass1), 0);
        cmp("lit_ca0_err2", 1, int'(err2), 6);
        cmp("lit_ca0_fvec2", 1, int'(fvec2), 7);
`endif

        // DUT slower than the configured latency
        fault   = '{0, 0};
        dut_lat = '{0, 3};
        idle(4);
        run(-1, -1, d1, d2);
        cmp("lit_latmis_err2", 1, int'(err2 != 0), 1);

        for (int r = 0; r < 5; r++) begin
            fault[0]   = $urandom_range(0, 3);
            fault[1]   = $urandom_range(0, 3);
            dut_lat[0] = $urandom_range(0, 1);
            dut_lat[1] = $urandom_range(0, 3);
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 16; k++) badmask[i][k] = 1'($urandom_range(0, 1));
            idle(4);
            run($urandom_range(2, 40), -1, d1, d2);
        end

        // reset during WAIT of vector 2 on inst2, then a clean recovery run
        fault   = '{0, 0};
        dut_lat = '{0, 2};
        idle(4);
        run(-1, 10, d1, d2);
        @(negedge clk);
        check_reset();
        idle(4);
        run(-1, -1, d1, d2);
        cmp("lit_recover_pass1", 0, int'(pass1), 1);
        cmp("lit_recover_pass2", 1, int'(pass2), 1);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ha_checker.md
# ha_checker

Synthesizable stimulus generator and response checker for the half-adder (semisumador) family and its WIDTH-bit generalisations.
- Drives every operand pair {a,b} into a DUT in ascending order, waits a fixed response latency, then compares the DUT's sum/carry against a+b.
- Accumulates an error count and captures the first failing vector.
- Sits at the DUT's output end as the hardware counterpart of the simulation stimulus/monitor benches, for on-board or co-simulation self-test.

## Interface
- WIDTH, 1: operand width; DUT computes {carry,sum} = a + b.
- LAT, 0: DUT response latency in clock cycles (0 = combinational DUT); legal range 0–15.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- test_a  out  WIDTH  operand a to DUT (registered).
- test_b  out  WIDTH  operand b to DUT (registered).
- dut_sum  in  WIDTH  DUT sum.
- dut_carry  in  1  DUT carry.
- busy  out  1  high in DRIVE, WAIT, CHECK.
- done  out  1  high in DONE.
- pass  out  1  done && err_cnt == 0.
- err_cnt  out  2*WIDTH+1  number of mismatching vectors in the current run; wide enough never to saturate.
- fail_valid  out  1  a mismatch has been captured this run.
- fail_vec  out  2*WIDTH  {a,b} of the first mismatch.

## Operation
- Internal vector counter vec, 2*WIDTH bits: a = vec[2W-1:W], b = vec[W-1:0].
- IDLE: outputs held at reset values.
  - start → clear vec, err_cnt, fail_valid, fail_vec → DRIVE.
- DRIVE, 1 cycle: load test_a/test_b from vec.
  - LAT = 0 → CHECK; otherwise → WAIT.
- WAIT, exactly LAT cycles, counted by a 4-bit down-counter; then → CHECK.
- CHECK, 1 cycle: sample dut_carry, dut_sum; expected = {1'b0,test_a} + {1'b0,test_b}, WIDTH+1 bits.
  - On mismatch: err_cnt += 1. If !fail_valid, set fail_valid and fail_vec = {test_a,test_b}.
  - If vec is all ones → DONE; else vec += 1 → DRIVE.
- DONE: test_a/test_b hold the last vector; err_cnt and fail_* hold their values.
  - start → same clearing actions as from IDLE → DRIVE, i.e. a new run.
- start in DRIVE, WAIT or CHECK is ignored.
- X/Z on dut inputs counts as a mismatch. This is a simulation-only effect; in hardware the compare is plain !=.

## Timing
- Reset values: state IDLE; test_a = test_b = 0; busy = done = pass = 0; err_cnt = 0; fail_valid = 0; fail_vec = 0.
- Reset asserted mid-run wins over all other inputs; the next cycle is IDLE with reset values.
- Cycle numbering for a run: cycle 0 is the cycle where start is sampled.
  - State is DRIVE in cycle 1.
  - test_a/test_b become valid in cycle 2.
  - CHECK for vector 0 occurs in cycle 2+LAT.
- Per-vector period: 2+LAT cycles.
- done rises at cycle 1 + 2^(2W)·(2+LAT).
  - WIDTH=1, LAT=0: done at cycle 9.
  - WIDTH=1, LAT=2: done at cycle 17.
- err_cnt and fail_* update in the cycle after CHECK (registered).
- pass is valid whenever done = 1.
- test_a/test_b are stable from DRIVE+1 through CHECK inclusive. DUT output must settle within LAT cycles of that.

## Configuration
- HA_CHECKER_STOP_ON_FAIL_EN defined: the first mismatch in CHECK moves to DONE instead of continuing.
  - err_cnt = 1, fail_valid = 1, pass = 0; test_a/test_b hold the failing vector.
- Undefined: the run always covers all 2^(2W) vectors.

## Test plan
- WIDTH=1, LAT=0, correct combinational half adder; start at cycle 0 → vectors 00,01,10,11 at 2-cycle spacing; done at cycle 9, pass=1, err_cnt=0, fail_valid=0.
- WIDTH=1, LAT=0, DUT with sum stuck at 0 → err_cnt=2 (vectors 01, 10), fail_vec=2'b01, pass=0, done at cycle 9.
- WIDTH=1, LAT=2, DUT with outputs registered twice → pass=1 at cycle 17. Same DUT run with LAT=1 → err_cnt>0.
- WIDTH=2, LAT=0, correct 2-bit adder → 16 vectors, done at cycle 33, err_cnt=0. Inject carry stuck at 0 → err_cnt=6, fail_vec=4'b0111.
- reset pulsed during WAIT of vector 2 → next cycle IDLE, all outputs zero. start pulsed during a run → ignored. start in DONE → counters cleared, new run completes identically.
- HA_CHECKER_STOP_ON_FAIL_EN with sum-stuck-0 DUT, WIDTH=1, LAT=0 → done after vector 01's CHECK (cycle 5), err_cnt=1, test_a=0, test_b=1.
